// File: rtl/seg_mux_pkg.sv
// rtl/seg_mux_pkg.sv - shared constants for the seven-segment digit multiplexer
//
// Purpose: holds the defaults and select-bit indices used by seg_sel_decode
//          and seg_multiplexer.
// Contents:
//   SEG_W_DEFAULT  default width of a segment pattern
//   BLANK_DEFAULT  all-ones source for the blank pattern (segments are active-low);
//                  truncate it to SEG_W bits to get the blank pattern
//   SEL_A..SEL_D   bit positions of each digit inside the one-hot select
package seg_mux_pkg;

  localparam int SEG_W_DEFAULT = 8;

  // Wide all-ones constant so a blank of any width up to 64 bits is a simple truncation.
  localparam logic [63:0] BLANK_DEFAULT = '1;

  localparam int SEL_A = 0;
  localparam int SEL_B = 1;
  localparam int SEL_C = 2;
  localparam int SEL_D = 3;

endpackage

// File: rtl/seg_sel_decode.sv
// rtl/seg_sel_decode.sv - one-hot digit select to index/valid decoder
//
// Purpose: turns the 4-bit one-hot select into a 2-bit digit index plus a
//          valid flag. The handling of multi-hot selects depends on the
//          configuration macro SEG_MUX_PRIORITY_EN.
//   SEG_MUX_PRIORITY_EN defined   : any non-zero select is valid; the lowest
//                                   set bit wins (A > B > C > D).
//   SEG_MUX_PRIORITY_EN undefined : only an exactly one-hot select is valid,
//                                   so a multi-hot select shows as blank.
// Ports:
//   select  in   4  one-hot select, bit0=A .. bit3=D
//   idx     out  2  index of the chosen digit (meaningful only when valid=1)
//   valid   out  1  1 when idx names a digit to display
module seg_sel_decode
  import seg_mux_pkg::*;
(
  input  logic [3:0] select,
  output logic [1:0] idx,
  output logic       valid
);

  always_comb begin
    idx = 2'(SEL_A);
    // Scan from the highest bit down so the lowest set bit is the last one
    // written; this gives the A > B > C > D priority and is also the correct
    // index whenever the select is exactly one-hot.
    for (int i = SEL_D; i >= SEL_A; i--) begin
      if (select[i]) begin
        idx = 2'(i);
      end
    end
  end

`ifdef SEG_MUX_PRIORITY_EN
  assign valid = |select;
`else
  assign valid = $onehot(select);
`endif

endmodule

// File: rtl/seg_multiplexer.sv
// rtl/seg_multiplexer.sv - registered four-digit seven-segment pattern multiplexer
//
// Purpose: each clock, loads the segment pattern of the selected digit into a
//          register that drives the display. Blank is shown when disabled, when
//          no digit is selected, or (without SEG_MUX_PRIORITY_EN) when more than
//          one digit is selected.
// Configuration: SEG_MUX_PRIORITY_EN (see seg_sel_decode).
// Parameters:
//   SEG_W   width of each pattern and of digit
//   BLANK   active-low pattern with every segment off
// Ports:
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous active-high reset; forces digit to BLANK
//   enable  in   1      1 = show the selected pattern, 0 = blank
//   A..D    in   SEG_W  patterns for digit positions 0..3
//   select  in   4      one-hot select, bit0=A .. bit3=D
//   digit   out  SEG_W  registered segment drive
module seg_multiplexer
  import seg_mux_pkg::*;
#(
  parameter int               SEG_W = SEG_W_DEFAULT,
  parameter logic [SEG_W-1:0] BLANK = SEG_W'(BLANK_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [SEG_W-1:0] A,
  input  logic [SEG_W-1:0] B,
  input  logic [SEG_W-1:0] C,
  input  logic [SEG_W-1:0] D,
  input  logic [3:0]       select,
  output logic [SEG_W-1:0] digit
);

  logic [1:0]       sel_idx;
  logic             sel_valid;
  logic [SEG_W-1:0] next_digit;

  seg_sel_decode u_decode (
    .select (select),
    .idx    (sel_idx),
    .valid  (sel_valid)
  );

  always_comb begin
    next_digit = BLANK;
    if (enable && sel_valid) begin
      case (sel_idx)
        2'(SEL_A): next_digit = A;
        2'(SEL_B): next_digit = B;
        2'(SEL_C): next_digit = C;
        2'(SEL_D): next_digit = D;
        default:   next_digit = BLANK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= BLANK;
    end else begin
      digit <= next_digit;
    end
  end

endmodule

// File: tb/tb_seg_multiplexer.sv
// tb/tb_seg_multiplexer.sv - self-checking bench for seg_multiplexer
module tb_seg_multiplexer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic [7:0] C = 8'h00;
  logic [7:0] D = 8'h00;
  logic [3:0] select = 4'h0;
  logic [7:0] digit;

  int checks = 0;
  int errors = 0;

  seg_multiplexer dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .select (select),
    .digit  (digit)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Display rules: disabled or no digit selected -> blank; one digit selected
  // -> that digit's pattern; several selected -> lowest-numbered digit with
  // priority enabled, blank otherwise.
  function automatic logic [7:0] model(input logic en, input logic [3:0] sel,
                                       input logic [7:0] pa, input logic [7:0] pb,
                                       input logic [7:0] pc, input logic [7:0] pd);
    logic [7:0] pats [4];
    int first;
    pats[0] = pa; pats[1] = pb; pats[2] = pc; pats[3] = pd;
    if (!en) return 8'hFF;
    if ($countones(sel) == 0) return 8'hFF;
    first = -1;
    for (int i = 0; i < 4; i++) begin
      if (sel[i] && first < 0) first = i;
    end
`ifdef SEG_MUX_PRIORITY_EN
    return pats[first];
`else
    if ($countones(sel) > 1) return 8'hFF;
    return pats[first];
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] expected);
    checks++;
    assert (digit === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, digit, expected);
    end
  endtask

  // Expected value is taken from the inputs as they stand before the edge.
  task automatic step(input string tag);
    logic [7:0] exp_v;
    exp_v = model(enable, select, A, B, C, D);
    @(posedge clk);
    #1;
    check(tag, exp_v);
  endtask

  initial begin
    // Asynchronous reset with no clock edge involved.
    #2;
    reset = 1'b1;
    #1;
    check("reset_initial", 8'hFF);

    A = 8'h96; B = 8'hB0; C = 8'hA4; D = 8'hF6;
    select = 4'h1;
    enable = 1'b1;
    @(posedge clk); #1;
    check("reset_hold", 8'hFF);
    @(negedge clk);
    reset = 1'b0;
    step("reset_release");
    check("reset_release_value", 8'h96);

    // Reset pulsed between edges while operating.
    #2;
    reset = 1'b1;
    #1;
    check("reset_midcycle", 8'hFF);
    @(negedge clk);
    reset = 1'b0;
    step("reset_rerelease");

    // One-hot sweep, each held two clocks.
    select = 4'h1; step("sweep_a0"); step("sweep_a1");
    select = 4'h2; step("sweep_b0"); check("sweep_b_value", 8'hB0); step("sweep_b1");
    select = 4'h4; step("sweep_c0"); check("sweep_c_value", 8'hA4); step("sweep_c1");
    select = 4'h8; step("sweep_d0"); check("sweep_d_value", 8'hF6); step("sweep_d1");

    // Enable off then on again, no warm-up.
    enable = 1'b0; step("enable_off"); check("enable_off_value", 8'hFF);
    enable = 1'b1; step("enable_on"); check("enable_on_value", 8'hF6);

    // Invalid selects.
    select = 4'h0; step("select_zero");
    select = 4'b0110; step("select_multi");
`ifdef SEG_MUX_PRIORITY_EN
    check("select_multi_value", 8'hB0);
`else
    check("select_multi_value", 8'hFF);
`endif

    // Mid-cycle change of A has no effect until the next edge.
    select = 4'h1; step("sample_prep");
    A = 8'h3C;
    #3;
    check("sample_midcycle", 8'h96);
    step("sample_edge");
    check("sample_edge_value", 8'h3C);

    // Randomized stimulus against the model.
    for (int n = 0; n < 300; n++) begin
      A = 8'($urandom); B = 8'($urandom); C = 8'($urandom); D = 8'($urandom);
      enable = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0: select = 4'($urandom);
        default: select = 4'(1 << $urandom_range(0, 3));
      endcase
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
